// File: rtl/aes_dec_round_ctrl.sv
// AES-128 iterative inverse-cipher round sequencer: one round per clock,
// round keys fetched 10..0 from the expanded-key store, inverse S-box bank
// external, inverse MixColumns local, plaintext returned on valid/ready.

// Inverse MixColumns on a full state: row words in, column words out.
module aes_inv_mix_cols (
   input  logic [3:0][31:0] row_i,
   output logic [3:0][31:0] col_o
);

   // Multiply by x in GF(2^8) modulo the AES polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a constant k < 16 as a sum of b, 2b, 4b, 8b.
   function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
      logic [7:0] x2;
      logic [7:0] x4;
      logic [7:0] x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return ({8{k[0]}} & b) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
   endfunction

   // Column c gathers byte c of every row word, then applies the 0e/0b/0d/09 matrix.
   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] a0;
      logic [7:0] a1;
      logic [7:0] a2;
      logic [7:0] a3;
      logic [7:0] b0;
      logic [7:0] b1;
      logic [7:0] b2;
      logic [7:0] b3;

      assign a0 = row_i[0][31-8*c -: 8];
      assign a1 = row_i[1][31-8*c -: 8];
      assign a2 = row_i[2][31-8*c -: 8];
      assign a3 = row_i[3][31-8*c -: 8];

      assign b0 = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
      assign b1 = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
      assign b2 = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
      assign b3 = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);

      assign col_o[c] = {b0, b1, b2, b3};
   end

endmodule

// Round sequencer top.
module aes_dec_round_ctrl (
   input  logic         sys_clk,
   input  logic         sys_rst_n,
   input  logic         key_ready,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic [3:0]   rk_addr,
   input  logic [127:0] rk_data,
   output logic [127:0] isb_in,
   input  logic [127:0] isb_out,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);

   localparam int unsigned BLK_W = 128;
   localparam int unsigned RK_AW = 4;
   localparam int unsigned RND_W = 4;
   localparam int unsigned NR    = 10;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      ROUND = 3'd2,
      FINAL = 3'd3,
      DONE  = 3'd4
   } fsm_e;

   fsm_e             fsm_q, fsm_d;
   logic [BLK_W-1:0] state_q, state_d;
   logic [RND_W-1:0] rnd_q, rnd_d;
   logic [RK_AW-1:0] rk_addr_q, rk_addr_d;
   logic             out_valid_q, out_valid_d;

   logic [BLK_W-1:0] mix_in;
   logic [3:0][31:0] mix_row;
   logic [3:0][31:0] mix_col;
   logic [BLK_W-1:0] mix_state;

   // InvShiftRows: byte s'[r][c] takes s[r][(c-r) mod 4]; pure wiring.
   for (genvar r = 0; r < 4; r++) begin : g_isr_row
      for (genvar c = 0; c < 4; c++) begin : g_isr_col
         assign isb_in[127-8*(4*c+r) -: 8] = state_q[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
   end

   // Round key is added before the mix; pack the sum as row words.
   assign mix_in = isb_out ^ rk_data;

   for (genvar r = 0; r < 4; r++) begin : g_mix_row
      assign mix_row[r] = {mix_in[127-8*r -: 8],
                           mix_in[127-8*(4+r) -: 8],
                           mix_in[127-8*(8+r) -: 8],
                           mix_in[127-8*(12+r) -: 8]};
   end

   aes_inv_mix_cols u_inv_mix_cols (
      .row_i (mix_row),
      .col_o (mix_col)
   );

   // Column words come back in column order, which is the state layout.
   assign mix_state = {mix_col[0], mix_col[1], mix_col[2], mix_col[3]};

   // Next-state, datapath and round-key address sequencing.
   always_comb begin
      fsm_d       = fsm_q;
      state_d     = state_q;
      rnd_d       = rnd_q;
      rk_addr_d   = rk_addr_q;
      out_valid_d = 1'b0;

      unique case (fsm_q)
         IDLE: begin
            rk_addr_d = RK_AW'(NR);
            if (in_valid && in_ready) begin
               state_d = in_data;
               fsm_d   = INIT;
            end
         end
         INIT: begin
            state_d   = state_q ^ rk_data;
            rk_addr_d = RK_AW'(NR - 1);
            rnd_d     = RND_W'(NR - 1);
            fsm_d     = ROUND;
         end
         ROUND: begin
            state_d = mix_state;
            if (rnd_q == RND_W'(1)) begin
               rk_addr_d = '0;
               rnd_d     = '0;
               fsm_d     = FINAL;
            end else begin
               rk_addr_d = rk_addr_q - RK_AW'(1);
               rnd_d     = rnd_q - RND_W'(1);
            end
         end
         FINAL: begin
            state_d     = isb_out ^ rk_data;
            rk_addr_d   = RK_AW'(NR);
            out_valid_d = 1'b1;
            fsm_d       = DONE;
         end
         DONE: begin
            out_valid_d = 1'b1;
            if (out_ready) begin
               out_valid_d = 1'b0;
               fsm_d       = IDLE;
            end
         end
         default: begin
            fsm_d = IDLE;
         end
      endcase
   end

   // State registers; reset aborts any block in flight.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         fsm_q       <= IDLE;
         state_q     <= '0;
         rnd_q       <= '0;
         rk_addr_q   <= RK_AW'(NR);
         out_valid_q <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         state_q     <= state_d;
         rnd_q       <= rnd_d;
         rk_addr_q   <= rk_addr_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Acceptance is only possible from IDLE with a complete key schedule.
   assign in_ready  = (fsm_q == IDLE) && key_ready;
   assign rk_addr   = rk_addr_q;
   assign out_valid = out_valid_q;
   assign out_data  = state_q;

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Directed and streaming checks for aes_dec_round_ctrl. The bench models the
// expanded-key store, the inverse S-box bank and a forward AES-128 encryptor.
module tb_aes_dec_round_ctrl;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

   logic         sys_clk = 1'b0;
   logic         sys_rst_n;
   logic         key_ready;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [3:0]   rk_addr;
   logic [127:0] rk_data;
   logic [127:0] isb_in;
   logic [127:0] isb_out;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   logic [7:0]   sbox     [256];
   logic [7:0]   inv_sbox [256];
   logic [127:0] rk_mem   [16];

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   aes_dec_round_ctrl dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key_ready (key_ready),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .rk_addr   (rk_addr),
      .rk_data   (rk_data),
      .isb_in    (isb_in),
      .isb_out   (isb_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   // Key store read through the registered address.
   assign rk_data = rk_mem[rk_addr];

   // External inverse S-box bank.
   always_comb begin
      isb_out = '0;
      for (int i = 0; i < 16; i++) isb_out[8*i +: 8] = inv_sbox[isb_in[8*i +: 8]];
   end

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xt(aa);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   // S-box from first principles: multiplicative inverse then affine map.
   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] b;
         logic [7:0] p;
         logic [7:0] s;
         b = 8'(x);
         p = 8'h01;
         for (int k = 0; k < 254; k++) p = gmul(p, b);
         s = p ^ rotl8(p, 1) ^ rotl8(p, 2) ^ rotl8(p, 3) ^ rotl8(p, 4) ^ 8'h63;
         sbox[x]     = s;
         inv_sbox[s] = b;
      end
   endtask

   task automatic expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
            t[31:24] = t[31:24] ^ rc;
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Forward cipher with the currently loaded schedule.
   function automatic logic [127:0] encrypt(input logic [127:0] pt);
      logic [127:0] s;
      logic [127:0] t;
      logic [7:0]   a0, a1, a2, a3;
      s = pt ^ rk_mem[0];
      for (int rd = 1; rd <= 10; rd++) begin
         for (int i = 0; i < 16; i++) s[8*i +: 8] = sbox[s[8*i +: 8]];
         t = '0;
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               t[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
         s = t;
         if (rd < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[127-8*(4*c)   -: 8];
               a1 = s[127-8*(4*c+1) -: 8];
               a2 = s[127-8*(4*c+2) -: 8];
               a3 = s[127-8*(4*c+3) -: 8];
               s[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                    a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                    a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                    xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
            end
         end
         s = s ^ rk_mem[rd];
      end
      return s;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [127:0] ct, output int acc);
      int n;
      in_data  = ct;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge sys_clk);
         n++;
      end
      if (!in_ready) begin
         check_val("accept_timeout", 128'(in_ready), 128'(1));
         in_valid = 1'b0;
         acc = -1;
      end else begin
         @(posedge sys_clk);
         @(negedge sys_clk);
         in_valid = 1'b0;
         acc = cyc;
      end
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 60) begin
         @(negedge sys_clk);
         lat++;
      end
      check_val("out_valid_seen", 128'(out_valid), 128'(1));
   endtask

   task automatic run_block(input logic [127:0] ct, input logic [127:0] pt);
      int acc;
      int lat;
      send(ct, acc);
      wait_out(lat);
      check_val("latency", 128'(lat), 128'(11));
      check_val("plaintext", out_data, pt);
      @(negedge sys_clk);
      check_val("out_valid_after_hs", 128'(out_valid), 128'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no end of test, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] pt2, ct2;
      logic [127:0] s_pt [8];
      logic [127:0] s_ct [8];
      int acc, lat;

      sys_rst_n = 1'b1;
      key_ready = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_data   = '0;
      for (int i = 0; i < 16; i++) rk_mem[i] = '0;
      build_sbox();

      // Reset values
      #1 sys_rst_n = 1'b0;
      repeat (2) @(negedge sys_clk);
      check_val("rst_out_valid", 128'(out_valid), 128'(0));
      check_val("rst_out_data", out_data, 128'(0));
      check_val("rst_rk_addr", 128'(rk_addr), 128'(10));
      check_val("rst_in_ready_nokey", 128'(in_ready), 128'(0));
      key_ready = 1'b1;
      #1 check_val("rst_in_ready_key", 128'(in_ready), 128'(1));
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);

      // FIPS-197 C.1
      expand(C1_KEY);
      run_block(C1_CT, C1_PT);

      // FIPS-197 B with the round-key address sequence
      expand(B_KEY);
      send(B_CT, acc);
      for (int k = 0; k <= 11; k++) begin
         check_val("rk_addr_seq", 128'(rk_addr), 128'((k <= 10) ? (10 - k) : 10));
         if (k < 11) @(negedge sys_clk);
      end
      check_val("b_out_valid_at_11", 128'(out_valid), 128'(1));
      check_val("b_plaintext", out_data, B_PT);
      @(negedge sys_clk);
      check_val("b_out_valid_after_hs", 128'(out_valid), 128'(0));

      // Back-pressure with a pending block
      expand(C1_KEY);
      pt2 = {$urandom, $urandom, $urandom, $urandom};
      ct2 = encrypt(pt2);
      out_ready = 1'b0;
      send(C1_CT, acc);
      wait_out(lat);
      check_val("bp_latency", 128'(lat), 128'(11));
      in_data  = ct2;
      in_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge sys_clk);
         check_val("bp_out_valid_held", 128'(out_valid), 128'(1));
         check_val("bp_out_data_held", out_data, C1_PT);
         check_val("bp_in_ready_low", 128'(in_ready), 128'(0));
      end
      out_ready = 1'b1;
      @(negedge sys_clk);
      check_val("bp_out_valid_after_hs", 128'(out_valid), 128'(0));
      check_val("bp_in_ready_after_hs", 128'(in_ready), 128'(1));
      send(ct2, acc);
      wait_out(lat);
      check_val("bp_pending_latency", 128'(lat), 128'(11));
      check_val("bp_pending_plaintext", out_data, pt2);
      @(negedge sys_clk);

      // key_ready gating
      key_ready = 1'b0;
      in_data   = C1_CT;
      in_valid  = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge sys_clk);
         check_val("kr_in_ready_low", 128'(in_ready), 128'(0));
         check_val("kr_no_accept_rk_addr", 128'(rk_addr), 128'(10));
      end
      check_val("kr_no_out_valid", 128'(out_valid), 128'(0));
      in_valid  = 1'b0;
      key_ready = 1'b1;
      @(negedge sys_clk);
      send(C1_CT, acc);
      repeat (3) @(negedge sys_clk);
      key_ready = 1'b0;
      #1 check_val("kr_drop_in_ready", 128'(in_ready), 128'(0));
      wait_out(lat);
      check_val("kr_drop_plaintext", out_data, C1_PT);
      @(negedge sys_clk);
      check_val("kr_drop_out_valid_after_hs", 128'(out_valid), 128'(0));
      key_ready = 1'b1;
      @(negedge sys_clk);

      // Reset during round 5
      send(C1_CT, acc);
      repeat (5) @(negedge sys_clk);
      #2 sys_rst_n = 1'b0;
      #1;
      check_val("mid_rst_out_valid", 128'(out_valid), 128'(0));
      check_val("mid_rst_out_data", out_data, 128'(0));
      check_val("mid_rst_rk_addr", 128'(rk_addr), 128'(10));
      check_val("mid_rst_in_ready", 128'(in_ready), 128'(1));
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      for (int k = 0; k < 14; k++) begin
         @(negedge sys_clk);
         check_val("mid_rst_no_out_valid", 128'(out_valid), 128'(0));
      end
      run_block(C1_CT, C1_PT);

      // Streaming: 8 random blocks with out_ready held high
      expand(B_KEY);
      for (int i = 0; i < 8; i++) begin
         s_pt[i] = {$urandom, $urandom, $urandom, $urandom};
         s_ct[i] = encrypt(s_pt[i]);
      end
      fork
         begin : producer
            int p_acc;
            int p_prev;
            p_prev = 0;
            for (int i = 0; i < 8; i++) begin
               send(s_ct[i], p_acc);
               if (i > 0) check_val("stream_spacing", 128'(p_acc - p_prev), 128'(13));
               p_prev = p_acc;
            end
         end
         begin : consumer
            for (int i = 0; i < 8; i++) begin
               int n;
               n = 0;
               while (!out_valid && n < 100) begin
                  @(negedge sys_clk);
                  n++;
               end
               check_val("stream_out_valid", 128'(out_valid), 128'(1));
               check_val("stream_plaintext", out_data, s_pt[i]);
               @(negedge sys_clk);
            end
         end
      join

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
